imm_gen_pipe: RTL and testbench

Registered, flow-controlled immediate generator for the decode stage. It replaces the purely combinational sign-extension path with a two-entry elastic stage, and it is parametrised for RV32 or RV64. It adds two immediate modes, shift-amount and CSR zimm, and precomputes the PC-relative target (pc + imm) so execute receives a ready branch/jump address. It sits between instruction fetch/decode control and the decode→execute pipeline register.

---
 rtl/imm_gen_pipe.sv | 123 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator for decode: format mux, pc-relative adder,
// and a two-entry elastic stage (output register + skid) in front of execute.
module imm_gen_pipe #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [2:0]            ImmSrc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ImmOp,
  output logic [DATA_WIDTH-1:0] TargetAddr
);

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("imm_gen_pipe: DATA_WIDTH must be 32 or 64");
  end

  // Bit 0 marks the output register full, bit 1 the skid entry full, so the
  // handshake outputs come straight off the state flops.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t state, state_nxt;

  logic [63:0]           imm64;
  logic [DATA_WIDTH-1:0] imm, tgt;
  logic [DATA_WIDTH-1:0] skid_imm, skid_tgt;
  logic                  accept, consume;
  logic                  load_out, load_skid, from_skid;
  logic                  unused;

  assign unused = ^{instr[6:0], imm64};

  // Built at 64 bits and truncated, so RV32 gets the same sign extension.
  always_comb begin
    imm64 = '0;
    case (ImmSrc)
      3'b001:  imm64 = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      3'b010:  imm64 = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
      3'b011:  imm64 = {{32{instr[31]}}, instr[31:12], 12'b0};
      3'b100:  imm64 = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
      3'b101:  imm64 = (DATA_WIDTH == 64) ? {58'b0, instr[25:20]}
                                          : {59'b0, instr[24:20]};
      3'b110:  imm64 = {59'b0, instr[19:15]};
      default: imm64 = {{52{instr[31]}}, instr[31:20]};
    endcase
  end

  assign imm = imm64[DATA_WIDTH-1:0];
  assign tgt = pc + imm;

  assign out_valid = state[0];
  assign in_ready  = ~state[1];
  assign accept    = in_valid & in_ready & ~flush;
  assign consume   = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    load_skid = 1'b0;
    from_skid = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            load_out  = 1'b1;
          end
        end
        ONE: begin
          if (accept && consume) begin
            load_out = 1'b1;
          end else if (accept) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (consume) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            state_nxt = ONE;
            from_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (load_out) begin
      ImmOp      <= imm;
      TargetAddr <= tgt;
    end else if (from_skid) begin
      ImmOp      <= skid_imm;
      TargetAddr <= skid_tgt;
    end
    if (load_skid) begin
      skid_imm <= imm;
      skid_tgt <= tgt;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: RV32 and RV64 instances, format decode,
// pc-relative wrap, backpressure ordering, flush and mid-stream reset.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v32 = 1'b0, rdy32, f32 = 1'b0, ov32, or32 = 1'b1;
  logic [31:0] ins32 = '0, pc32 = '0, imm32, tgt32;
  logic [2:0]  src32 = '0;

  logic        v64 = 1'b0, rdy64, f64 = 1'b0, ov64, or64 = 1'b1;
  logic [31:0] ins64 = '0;
  logic [63:0] pc64 = '0, imm64, tgt64;
  logic [2:0]  src64 = '0;

  int checks = 0;
  int errors = 0;

  imm_gen_pipe #(.DATA_WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .instr(ins32),
    .pc(pc32), .ImmSrc(src32), .flush(f32), .out_valid(ov32),
    .out_ready(or32), .ImmOp(imm32), .TargetAddr(tgt32)
  );

  imm_gen_pipe #(.DATA_WIDTH(64)) u64 (
    .clk(clk), .rst(rst), .in_valid(v64), .in_ready(rdy64), .instr(ins64),
    .pc(pc64), .ImmSrc(src64), .flush(f64), .out_valid(ov64),
    .out_ready(or64), .ImmOp(imm64), .TargetAddr(tgt64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle transaction with out_ready high; result is checked right after the edge.
  task automatic send32(input string tag, input logic [31:0] i, input logic [31:0] p,
                        input logic [2:0] s, input logic [31:0] ei, input logic [31:0] et);
    v32 = 1'b1; ins32 = i; pc32 = p; src32 = s;
    tick();
    v32 = 1'b0;
    check({tag, ".valid"}, {63'b0, ov32}, 64'd1);
    check({tag, ".imm"}, {32'b0, imm32}, {32'b0, ei});
    check({tag, ".tgt"}, {32'b0, tgt32}, {32'b0, et});
  endtask

  task automatic send64(input string tag, input logic [31:0] i, input logic [63:0] p,
                        input logic [2:0] s, input logic [63:0] ei, input logic [63:0] et);
    v64 = 1'b1; ins64 = i; pc64 = p; src64 = s;
    tick();
    v64 = 1'b0;
    check({tag, ".valid"}, {63'b0, ov64}, 64'd1);
    check({tag, ".imm"}, imm64, ei);
    check({tag, ".tgt"}, tgt64, et);
  endtask

  // Present an I-type "addi x1,x0,n" on the RV32 instance, pc=0.
  task automatic present32(input logic [11:0] n);
    v32 = 1'b1; ins32 = {n, 20'h00093}; pc32 = '0; src32 = 3'b000;
  endtask

  initial begin
    tick();
    tick();
    check("rst.ov32", {63'b0, ov32}, 64'd0);
    check("rst.rdy32", {63'b0, rdy32}, 64'd1);
    check("rst.ov64", {63'b0, ov64}, 64'd0);
    check("rst.rdy64", {63'b0, rdy64}, 64'd1);
    rst = 1'b0;

    // RV32 formats, back to back at full throughput
    send32("i32",     32'hFFF00093, 32'h100,  3'b000, 32'hFFFFFFFF, 32'h000000FF);
    check("thru.rdy", {63'b0, rdy32}, 64'd1);
    send32("b32",     32'hFE000EE3, 32'h200,  3'b010, 32'hFFFFFFFC, 32'h000001FC);
    send32("u32",     32'h123450B7, 32'h1000, 3'b011, 32'h12345000, 32'h12346000);
    send32("s32",     32'hFE112E23, 32'h10,   3'b001, 32'hFFFFFFFC, 32'h0000000C);
    send32("j32",     32'h0080006F, 32'h40,   3'b100, 32'h00000008, 32'h00000048);
    send32("shamt32", 32'h4210D093, 32'h0,    3'b101, 32'h00000001, 32'h00000001);
    send32("zimm32",  32'h3401D073, 32'h4,    3'b110, 32'h00000003, 32'h00000007);
    send32("src7",    32'hFFF00093, 32'h8,    3'b111, 32'hFFFFFFFF, 32'h00000007);
    tick();
    check("drain.ov32", {63'b0, ov32}, 64'd0);

    // RV64 sweep
    send64("u64",     32'h800000B7, 64'h0,  3'b011, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000);
    send64("shamt64", 32'h4210D093, 64'h0,  3'b101, 64'd33, 64'd33);
    send64("zimm64",  32'h3401D073, 64'h10, 3'b110, 64'd3, 64'h13);
    send64("wrap64",  32'h02000093, 64'hFFFFFFFFFFFFFFF0, 3'b000, 64'h20, 64'h10);
    send64("b64",     32'hFE000EE3, 64'h200, 3'b010, 64'hFFFFFFFFFFFFFFFC, 64'h1FC);

    // Backpressure: A, B, C with out_ready low
    or32 = 1'b0;
    present32(12'd1); tick();
    check("bp.A.ov", {63'b0, ov32}, 64'd1);
    check("bp.A.rdy", {63'b0, rdy32}, 64'd1);
    present32(12'd2); tick();
    check("bp.B.rdy", {63'b0, rdy32}, 64'd0);
    check("bp.B.out", {32'b0, imm32}, 64'd1);
    present32(12'd3); tick();
    check("bp.C.hold", {32'b0, imm32}, 64'd1);
    check("bp.C.rdy", {63'b0, rdy32}, 64'd0);
    or32 = 1'b1; tick();
    check("bp.out2", {32'b0, imm32}, 64'd2);
    check("bp.out2.rdy", {63'b0, rdy32}, 64'd1);
    tick();
    v32 = 1'b0;
    check("bp.out3", {32'b0, imm32}, 64'd3);
    check("bp.out3.ov", {63'b0, ov32}, 64'd1);
    tick();
    check("bp.empty", {63'b0, ov32}, 64'd0);

    // Flush in FULL with D presented
    or32 = 1'b0;
    present32(12'd1); tick();
    present32(12'd2); tick();
    present32(12'h0D); f32 = 1'b1; tick();
    f32 = 1'b0; v32 = 1'b0;
    check("fl.ov", {63'b0, ov32}, 64'd0);
    check("fl.rdy", {63'b0, rdy32}, 64'd1);
    present32(12'h0E); tick();
    v32 = 1'b0;
    check("fl.E.ov", {63'b0, ov32}, 64'd1);
    check("fl.E.imm", {32'b0, imm32}, 64'h0E);
    or32 = 1'b1; tick();
    check("fl.noD", {63'b0, ov32}, 64'd0);

    // Reset mid-stream in FULL with input presented
    or32 = 1'b0;
    present32(12'd4); tick();
    present32(12'd5); tick();
    present32(12'd6); rst = 1'b1; tick();
    rst = 1'b0; v32 = 1'b0;
    check("mrst.ov", {63'b0, ov32}, 64'd0);
    check("mrst.rdy", {63'b0, rdy32}, 64'd1);
    present32(12'd7); tick();
    v32 = 1'b0;
    check("mrst.F.ov", {63'b0, ov32}, 64'd1);
    check("mrst.F.imm", {32'b0, imm32}, 64'd7);
    check("mrst.F.rdy", {63'b0, rdy32}, 64'd1);
    or32 = 1'b1; tick();
    check("mrst.drain", {63'b0, ov32}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
